k12a_fetch_seq: RTL and testbench
=================================

K12A_FETCH_SEQ -- requirements
Module: k12a_fetch_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have port clock  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port mem_rdata  in  8  memory read data, valid when mem_ready=1.
REQ-005 SHALL have port mem_ready  in  1  memory completes current read this cycle.
REQ-006 SHALL have port skip  in  1  current skip flag from skip register.
REQ-007 SHALL have port ex_done  in  1  execute unit finished current instruction.
REQ-008 SHALL have port ex_cond  in  1  finished instruction is a conditional-skip instruction.
REQ-009 SHALL have port ex_cond_inv  in  1  conditional-skip uses inverted condition.
REQ-010 SHALL have port ex_jump  in  1  finished instruction loads PC.
REQ-011 SHALL have port ex_target  in  16  jump target address.
REQ-012 SHALL have port ex_halt  in  1  finished instruction halts the core.
REQ-013 SHALL have port mem_rd  out  1  memory read request.
REQ-014 SHALL have port mem_addr  out  16  memory read address (equals pc).
REQ-015 SHALL have port inst  out  16  fetched instruction, high byte first.
REQ-016 SHALL have port inst_valid  out  1  one-cycle pulse: inst dispatched to execute.
REQ-017 SHALL have port skip_sel  out  skip_sel_t  select driven to skip register.
REQ-018 SHALL have port pc  out  16  program counter.
REQ-019 SHALL have port halted  out  1  core halted.

Function
REQ-020 SHALL implement states FETCH_HI, FETCH_LO, DISPATCH, EXECUTE, HALT.
REQ-021 FETCH_HI/FETCH_LO SHALL assert mem_rd=1, mem_addr=pc; hold state while mem_ready=0.
REQ-022 On mem_ready in FETCH_HI: inst[15:8]<=mem_rdata, pc<=pc+1, go FETCH_LO; in FETCH_LO: inst[7:0]<=mem_rdata, pc<=pc+1, go DISPATCH.
REQ-023 PC increment SHALL wrap 16'hFFFF -> 16'h0000 (byte pair may straddle wrap).
REQ-024 DISPATCH with skip=1: inst_valid=0, skip_sel=SKIP_SEL_0 for that cycle, go FETCH_HI (instruction discarded).
REQ-025 DISPATCH with skip=0: inst_valid=1 for exactly that cycle, go EXECUTE.
REQ-026 EXECUTE SHALL hold until ex_done=1; ex_* inputs sampled only in the ex_done cycle.
REQ-027 On ex_done: skip_sel = ex_cond ? (ex_cond_inv ? SKIP_SEL_CONDITION_N : SKIP_SEL_CONDITION) : SKIP_SEL_0.
REQ-028 On ex_done with ex_jump=1: pc<=ex_target; else pc unchanged.
REQ-029 On ex_done: ex_halt=1 -> HALT (takes priority over fetch; jump still applied); else FETCH_HI.
REQ-030 HALT SHALL be terminal until reset; halted=1, mem_rd=0.
REQ-031 skip_sel SHALL be SKIP_SEL_HOLD in every cycle/state not covered by REQ-024/027.
REQ-032 mem_rd SHALL be 0 in DISPATCH, EXECUTE, HALT.

Reset
REQ-033 reset_n=0 at a rising edge SHALL force state FETCH_HI, pc=RESET_PC, inst=16'h0000, regardless of state, including mid-fetch with mem_ready pending.
REQ-034 During reset cycle outputs SHALL be: inst_valid=0, skip_sel=SKIP_SEL_HOLD, halted=0, mem_rd=0.
REQ-035 First cycle after reset release SHALL assert mem_rd=1 with mem_addr=RESET_PC.

Configuration
REQ-036 Macro K12A_SKIP_COUNT_EN SHALL, when defined, add output skip_count (8 bits): count of discarded instructions (REQ-024), saturating at 8'hFF, reset to 0.
REQ-037 Without K12A_SKIP_COUNT_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-038 Reset, mem_ready=1, bytes 8'h12,8'h34 -> inst_valid pulse in cycle 3 with inst=16'h1234, pc=RESET_PC+2.
REQ-039 mem_ready low 3 cycles in FETCH_LO -> mem_addr stable, no state advance, inst_valid delayed 3 cycles.
REQ-040 ex_done with ex_cond=1, ex_cond_inv=1 -> skip_sel=SKIP_SEL_CONDITION_N one cycle; next DISPATCH with skip=1 -> no inst_valid, skip_sel=SKIP_SEL_0, skip_count increments by 1 (macro on).
REQ-041 pc=16'hFFFF, fetch -> high byte from 16'hFFFF, low byte from 16'h0000, pc=16'h0001.
REQ-042 ex_done with ex_jump=1, ex_target=16'h0400, ex_halt=1 -> pc=16'h0400, halted=1, mem_rd stays 0 for 10 cycles.
REQ-043 reset_n=0 asserted in EXECUTE and in FETCH_LO -> next cycle state FETCH_HI, pc=RESET_PC, skip_count=0.

Source files
------------

// File: rtl/k12a_fetch_seq.sv
// K12A instruction fetch sequencer: two-byte fetch, dispatch/skip, execute handshake, halt.
// Optional K12A_SKIP_COUNT_EN adds an 8-bit saturating count of skipped instructions.

package k12a_fetch_seq_pkg;
  typedef enum logic [1:0] {
    SKIP_SEL_HOLD        = 2'd0,
    SKIP_SEL_0           = 2'd1,
    SKIP_SEL_CONDITION   = 2'd2,
    SKIP_SEL_CONDITION_N = 2'd3
  } skip_sel_t;
endpackage

module k12a_fetch_seq
  import k12a_fetch_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  input  logic        skip,
  input  logic        ex_done,
  input  logic        ex_cond,
  input  logic        ex_cond_inv,
  input  logic        ex_jump,
  input  logic [15:0] ex_target,
  input  logic        ex_halt,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] inst,
  output logic        inst_valid,
  output skip_sel_t   skip_sel,
  output logic [15:0] pc,
`ifdef K12A_SKIP_COUNT_EN
  output logic [7:0]  skip_count,
`endif
  output logic        halted
);

  localparam int unsigned ADDR_W = 16;

  localparam logic [2:0] FETCH_HI = 3'd0;
  localparam logic [2:0] FETCH_LO = 3'd1;
  localparam logic [2:0] DISPATCH = 3'd2;
  localparam logic [2:0] EXECUTE  = 3'd3;
  localparam logic [2:0] HALT     = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [15:0]       inst_nxt;

  // State, pc and instruction register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= FETCH_HI;
      pc    <= RESET_PC;
      inst  <= 16'h0000;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      inst  <= inst_nxt;
    end
  end

  assign mem_addr = pc;

  // Next-state and per-state outputs; outputs stay idle while reset_n is low
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    inst_nxt   = inst;
    mem_rd     = 1'b0;
    inst_valid = 1'b0;
    skip_sel   = SKIP_SEL_HOLD;
    halted     = 1'b0;
    if (reset_n) begin
      case (state)
        FETCH_HI: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            inst_nxt[15:8] = mem_rdata;
            pc_nxt         = pc + ADDR_W'(1);
            state_nxt      = FETCH_LO;
          end
        end
        FETCH_LO: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            inst_nxt[7:0] = mem_rdata;
            pc_nxt        = pc + ADDR_W'(1);
            state_nxt     = DISPATCH;
          end
        end
        DISPATCH: begin
          if (skip) begin
            skip_sel  = SKIP_SEL_0;
            state_nxt = FETCH_HI;
          end else begin
            inst_valid = 1'b1;
            state_nxt  = EXECUTE;
          end
        end
        EXECUTE: begin
          if (ex_done) begin
            if (ex_cond) begin
              skip_sel = ex_cond_inv ? SKIP_SEL_CONDITION_N : SKIP_SEL_CONDITION;
            end else begin
              skip_sel = SKIP_SEL_0;
            end
            if (ex_jump) begin
              pc_nxt = ex_target;
            end
            state_nxt = ex_halt ? HALT : FETCH_HI;
          end
        end
        HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_nxt = FETCH_HI;
        end
      endcase
    end
  end

`ifdef K12A_SKIP_COUNT_EN
  // Saturating count of instructions discarded in DISPATCH
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      skip_count <= 8'h00;
    end else if (state == DISPATCH && skip && skip_count != 8'hFF) begin
      skip_count <= skip_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_k12a_fetch_seq.sv
// Directed bench for k12a_fetch_seq: expected values queued as stimulus is driven, popped at sampling.
// Skip-count checks are active when K12A_SKIP_COUNT_EN is defined.

module tb_k12a_fetch_seq;
  import k12a_fetch_seq_pkg::*;

  localparam logic [15:0] RST_PC = 16'h0100;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        skip;
  logic        ex_done;
  logic        ex_cond;
  logic        ex_cond_inv;
  logic        ex_jump;
  logic [15:0] ex_target;
  logic        ex_halt;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] inst;
  logic        inst_valid;
  skip_sel_t   skip_sel;
  logic [15:0] pc;
  logic        halted;
`ifdef K12A_SKIP_COUNT_EN
  logic [7:0]  skip_count;
`endif

  logic [7:0] memb [0:65535];

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  k12a_fetch_seq #(.RESET_PC(RST_PC)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .skip       (skip),
    .ex_done    (ex_done),
    .ex_cond    (ex_cond),
    .ex_cond_inv(ex_cond_inv),
    .ex_jump    (ex_jump),
    .ex_target  (ex_target),
    .ex_halt    (ex_halt),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .inst       (inst),
    .inst_valid (inst_valid),
    .skip_sel   (skip_sel),
    .pc         (pc),
`ifdef K12A_SKIP_COUNT_EN
    .skip_count (skip_count),
`endif
    .halted     (halted)
  );

  always #5 clock = ~clock;

  assign mem_rdata = memb[mem_addr];

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic want(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) passed++;
      else $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) memb[i] = 8'h00;
    memb[16'h0100] = 8'h12; memb[16'h0101] = 8'h34;
    memb[16'h0102] = 8'hAB; memb[16'h0103] = 8'hCD;
    memb[16'h0104] = 8'h56; memb[16'h0105] = 8'h78;
    memb[16'hFFFF] = 8'h5A; memb[16'h0000] = 8'hA5;

    reset_n = 1'b0; mem_ready = 1'b1; skip = 1'b0;
    ex_done = 1'b0; ex_cond = 1'b0; ex_cond_inv = 1'b0;
    ex_jump = 1'b0; ex_target = 16'h0000; ex_halt = 1'b0;

    // Reset cycle
    cyc();
    want("rst_mem_rd", 16'h0); want("rst_inst_valid", 16'h0);
    want("rst_skip_sel", 16'(SKIP_SEL_HOLD)); want("rst_halted", 16'h0);
    want("rst_pc", RST_PC); want("rst_inst", 16'h0000);
    #1;
    check(16'(mem_rd)); check(16'(inst_valid)); check(16'(skip_sel));
    check(16'(halted)); check(pc); check(inst);

    // Release: fetch 12,34
    reset_n = 1'b1;
    want("rel_mem_rd", 16'h1); want("rel_mem_addr", RST_PC);
    #1; check(16'(mem_rd)); check(mem_addr);
    cyc();
    want("lo_mem_addr", RST_PC + 16'd1);
    #1; check(mem_addr);
    cyc();
    want("disp_valid", 16'h1); want("disp_inst", 16'h1234); want("disp_pc", RST_PC + 16'd2);
    want("disp_mem_rd", 16'h0);
    #1; check(16'(inst_valid)); check(inst); check(pc); check(16'(mem_rd));

    // Execute hold, then conditional-inverted skip
    cyc();
    want("ex_hold_valid", 16'h0); want("ex_hold_sel", 16'(SKIP_SEL_HOLD)); want("ex_mem_rd", 16'h0);
    #1; check(16'(inst_valid)); check(16'(skip_sel)); check(16'(mem_rd));
    cyc();
    ex_done = 1'b1; ex_cond = 1'b1; ex_cond_inv = 1'b1;
    want("ex_cond_n_sel", 16'(SKIP_SEL_CONDITION_N));
    #1; check(16'(skip_sel));
    cyc();
    ex_done = 1'b0; ex_cond = 1'b0; ex_cond_inv = 1'b0; skip = 1'b1;
    want("post_ex_sel", 16'(SKIP_SEL_HOLD)); want("fhi_addr", RST_PC + 16'd2);
    #1; check(16'(skip_sel)); check(mem_addr);

    // FETCH_LO stalled three cycles
    cyc();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      want("stall_addr", RST_PC + 16'd3); want("stall_rd", 16'h1); want("stall_valid", 16'h0);
      #1; check(mem_addr); check(16'(mem_rd)); check(16'(inst_valid));
      cyc();
    end
    mem_ready = 1'b1;
    want("stall_release_addr", RST_PC + 16'd3);
    #1; check(mem_addr);

    // Discarded instruction in DISPATCH
    cyc();
    want("skip_valid", 16'h0); want("skip_sel0", 16'(SKIP_SEL_0)); want("skip_inst", 16'hABCD);
    #1; check(16'(inst_valid)); check(16'(skip_sel)); check(inst);
    cyc();
    skip = 1'b0;
    want("after_skip_rd", 16'h1); want("after_skip_addr", RST_PC + 16'd4);
`ifdef K12A_SKIP_COUNT_EN
    want("skip_count_1", 16'h0001);
`endif
    #1; check(16'(mem_rd)); check(mem_addr);
`ifdef K12A_SKIP_COUNT_EN
    check(16'(skip_count));
`endif

    // Fetch 5678, jump to FFFF
    cyc(); cyc();
    want("inst_5678", 16'h5678); want("valid_5678", 16'h1);
    #1; check(inst); check(16'(inst_valid));
    cyc();
    ex_done = 1'b1; ex_jump = 1'b1; ex_target = 16'hFFFF;
    want("jump_sel0", 16'(SKIP_SEL_0));
    #1; check(16'(skip_sel));
    cyc();
    ex_done = 1'b0; ex_jump = 1'b0;
    want("wrap_hi_addr", 16'hFFFF);
    #1; check(mem_addr);
    cyc();
    want("wrap_lo_addr", 16'h0000);
    #1; check(mem_addr);
    cyc();
    want("wrap_inst", 16'h5AA5); want("wrap_pc", 16'h0001); want("wrap_valid", 16'h1);
    #1; check(inst); check(pc); check(16'(inst_valid));

    // Reset asserted in EXECUTE
    cyc();
    reset_n = 1'b0;
    cyc();
    want("rx_pc", RST_PC); want("rx_inst", 16'h0000); want("rx_mem_rd", 16'h0);
`ifdef K12A_SKIP_COUNT_EN
    want("rx_skip_count", 16'h0000);
`endif
    #1; check(pc); check(inst); check(16'(mem_rd));
`ifdef K12A_SKIP_COUNT_EN
    check(16'(skip_count));
`endif
    reset_n = 1'b1;
    want("rx_rel_addr", RST_PC); want("rx_rel_rd", 16'h1);
    #1; check(mem_addr); check(16'(mem_rd));

    // Reset asserted in FETCH_LO with a read pending
    cyc();
    mem_ready = 1'b0; reset_n = 1'b0;
    want("rl_lo_addr", RST_PC + 16'd1);
    #1; check(mem_addr);
    cyc();
    want("rl_pc", RST_PC); want("rl_inst", 16'h0000);
    #1; check(pc); check(inst);
    reset_n = 1'b1; mem_ready = 1'b1;
    want("rl_rel_addr", RST_PC);
    #1; check(mem_addr);

    // Fetch, then jump+halt
    cyc(); cyc();
    want("h_valid", 16'h1);
    #1; check(16'(inst_valid));
    cyc();
    ex_done = 1'b1; ex_jump = 1'b1; ex_target = 16'h0400; ex_halt = 1'b1;
    want("h_halted_pre", 16'h0);
    #1; check(16'(halted));
    cyc();
    ex_done = 1'b0; ex_jump = 1'b0; ex_halt = 1'b0; ex_target = 16'h0000;
    want("h_pc", 16'h0400);
    #1; check(pc);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      ex_done = i[1];
      want("h_halted", 16'h1); want("h_mem_rd", 16'h0); want("h_valid_off", 16'h0);
      #1; check(16'(halted)); check(16'(mem_rd)); check(16'(inst_valid));
      cyc();
    end
    ex_done = 1'b0;
    want("h_pc_end", 16'h0400);
    #1; check(pc);

    if (sb.size() != 0) begin
      total++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
